eth_hdr_strip: RTL and testbench
================================

Name: eth_hdr_strip

Overview:
- Sits directly downstream of the Beehive RX converter and consumes its frame-queue read interface (val/data/startframe/frame_size/endframe/padbytes/rdy).
- Removes the 14-byte Ethernet header from each frame and presents dst MAC, src MAC, ethertype and payload size on a one-entry metadata channel.
- Re-aligns the payload so that payload byte 0 sits in the MSB byte of the first output line, and delivers it on a val/rdy stream with last and padbytes.
- Drops runt frames and lines that arrive out of frame.

Parameters:
- DATA_W, 256, bus width in bits; B = DATA_W/8 bytes per line; must be at least 128.
- PADBYTES_W, $clog2(DATA_W/8), width of the padbytes fields.
- SIZE_W, 16, width of the frame and payload size fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- src_eth_strip_val  in  1  input line valid.
- src_eth_strip_data  in  DATA_W  input line; byte 0 occupies data[DATA_W-1:DATA_W-8].
- src_eth_strip_startframe  in  1  first line of a frame.
- src_eth_strip_frame_size  in  SIZE_W  frame length in bytes; valid on the startframe line.
- src_eth_strip_endframe  in  1  last line of a frame.
- src_eth_strip_padbytes  in  PADBYTES_W  unused trailing bytes; valid on the endframe line.
- eth_strip_src_rdy  out  1  input line accepted when val and rdy are both high.
- eth_strip_hdr_val  out  1  metadata valid.
- eth_strip_hdr_dst_mac  out  48  frame bytes 0..5.
- eth_strip_hdr_src_mac  out  48  frame bytes 6..11.
- eth_strip_hdr_ethertype  out  16  frame bytes 12..13.
- eth_strip_hdr_payload_size  out  SIZE_W  frame_size-14.
- hdr_eth_strip_rdy  in  1  metadata consumer ready.
- eth_strip_pay_val  out  1  payload line valid.
- eth_strip_pay_data  out  DATA_W  payload line; unused bytes are zero.
- eth_strip_pay_last  out  1  last payload line of the frame.
- eth_strip_pay_padbytes  out  PADBYTES_W  unused trailing bytes; nonzero only on the last line.
- pay_eth_strip_rdy  in  1  payload consumer ready.
- eth_strip_drop_cnt  out  16  wrapping count of dropped frames and stray lines.

Behaviour:
- Reset: all val outputs, pay_last, pay_padbytes, pay_data, the header fields, drop_cnt and the tail register clear to 0; state returns to FIRST.
  - rst_n asserted mid-frame discards any partial frame.
  - After reset the block waits for the next startframe line.
- Output registers: the header and payload outputs are each a single register.
  - A register loads when its val is low or its rdy is high in that cycle.
  - val stays high until the rdy handshake.
  - Data stays stable while val is high and rdy is low.
- Notation: V = B - padbytes, the number of valid bytes in the endframe line.
- Tail register: holds bytes 14..B-1 of the previously accepted line, which is B-14 bytes.
- Payload line formation: each payload line is {tail, bytes 0..13 of the current line}.
- State FIRST:
  - rdy = header slot free.
  - Accepted line without startframe: discard it, increment drop_cnt, stay in FIRST.
  - startframe with frame_size < 15: discard the line, increment drop_cnt. Stay in FIRST if endframe is also set, otherwise go to DROP. Nothing is emitted.
  - Otherwise: load the header register; header is visible on the cycle after acceptance.
  - Not endframe: latch tail, go to BODY.
  - Endframe (single-line frame): latch tail, go to DRAIN with drain padbytes = padbytes+14.
- State BODY:
  - rdy = payload slot free.
  - Each accepted line emits {tail, cur[0..13]} and latches the new tail.
  - Endframe with V <= 14: that emitted line has last=1 and padbytes = 14-V, bytes beyond the valid ones are zeroed; go to FIRST.
  - Endframe with V > 14: emitted line has last=0; go to DRAIN with drain padbytes = padbytes+14.
- State DRAIN:
  - rdy = 0.
  - When the payload slot is free, emit the tail left-aligned, zero-filled, last=1, with the stored padbytes; go to FIRST.
- State DROP:
  - rdy = 1; lines are consumed silently.
  - On endframe, go to FIRST.
- Latency:
  - Header: 1 cycle after the startframe line is accepted.
  - Payload line k: 1 cycle after input line k+1 is accepted, or 1 cycle after entering DRAIN with a free slot.
- Input protocol: a startframe line while in BODY is not recoverable and is out of contract; the input queue guarantees framing.
- Total payload bytes emitted per frame = frame_size-14.
- Simultaneous load and drain of an output register in the same cycle is a pass-through with no bubble.

Test Plan (B=32):
- 64-byte frame, 2 lines, pad 0 -> header shows bytes 0..13 and payload_size 50; payload line 1 = frame bytes 14..45, last=0; line 2 = bytes 46..63, pad 14, last=1.
- 20-byte single-line frame, pad 12 -> payload_size 6; one payload line = bytes 14..19, pad 26, last=1.
- 46-byte frame, second line pad 18 -> exactly one payload line = bytes 14..45, pad 0, last=1; no DRAIN cycle.
- 10-byte runt, then 64-byte frame -> no output for the runt, drop_cnt=1; second frame output identical to scenario 1.
- hdr_rdy held low 20 cycles, pay_rdy randomly toggled over 100 back-to-back 64-byte frames -> src rdy low while the header slot is full; scoreboard shows no lost, duplicated or reordered bytes.
- rst_n pulsed low in the middle of BODY -> vals are 0 during reset; the next frame is processed correctly and drop_cnt=0.

Source files
------------

// File: rtl/eth_hdr_strip.sv
// Strips the 14-byte Ethernet header from Beehive RX frame-queue lines, emits the
// header fields as one metadata beat and re-aligns the payload to start at the MSB byte.
module eth_hdr_strip #(
  parameter int DATA_W     = 256,
  parameter int PADBYTES_W = $clog2(DATA_W/8),
  parameter int SIZE_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_eth_strip_val,
  input  logic [DATA_W-1:0]     src_eth_strip_data,
  input  logic                  src_eth_strip_startframe,
  input  logic [SIZE_W-1:0]     src_eth_strip_frame_size,
  input  logic                  src_eth_strip_endframe,
  input  logic [PADBYTES_W-1:0] src_eth_strip_padbytes,
  output logic                  eth_strip_src_rdy,
  output logic                  eth_strip_hdr_val,
  output logic [47:0]           eth_strip_hdr_dst_mac,
  output logic [47:0]           eth_strip_hdr_src_mac,
  output logic [15:0]           eth_strip_hdr_ethertype,
  output logic [SIZE_W-1:0]     eth_strip_hdr_payload_size,
  input  logic                  hdr_eth_strip_rdy,
  output logic                  eth_strip_pay_val,
  output logic [DATA_W-1:0]     eth_strip_pay_data,
  output logic                  eth_strip_pay_last,
  output logic [PADBYTES_W-1:0] eth_strip_pay_padbytes,
  input  logic                  pay_eth_strip_rdy,
  output logic [15:0]           eth_strip_drop_cnt
);

  localparam int B      = DATA_W / 8;
  localparam int HDR_W  = 112;
  localparam int TAIL_W = DATA_W - HDR_W;

  typedef enum logic [1:0] {FIRST, BODY, DRAIN, DROP} state_t;

  state_t                r_state;
  logic [TAIL_W-1:0]     r_tail;
  logic [PADBYTES_W-1:0] r_drain_pad;
  logic                  r_hdr_val;
  logic [47:0]           r_hdr_dst;
  logic [47:0]           r_hdr_src;
  logic [15:0]           r_hdr_type;
  logic [SIZE_W-1:0]     r_hdr_size;
  logic                  r_pay_val;
  logic [DATA_W-1:0]     r_pay_data;
  logic                  r_pay_last;
  logic [PADBYTES_W-1:0] r_pay_pad;
  logic [15:0]           r_drop_cnt;

  logic w_hdr_free;
  logic w_pay_free;
  logic w_src_rdy;
  logic w_acc;
  logic w_runt;
  logic w_short_end;

  // Zero the lowest 'pad' bytes of a line so unused bytes never leak input padding.
  function automatic logic [DATA_W-1:0] f_zero_pad(input logic [DATA_W-1:0] d,
                                                   input logic [PADBYTES_W-1:0] pad);
    logic [DATA_W-1:0] r;
    r = d;
    for (int i = 0; i < B; i++) begin
      if (i < int'(pad)) r[i*8 +: 8] = 8'h00;
    end
    return r;
  endfunction

  assign w_hdr_free  = !r_hdr_val || hdr_eth_strip_rdy;
  assign w_pay_free  = !r_pay_val || pay_eth_strip_rdy;
  assign w_runt      = src_eth_strip_frame_size < SIZE_W'(15);
  // Endframe line holds at most 14 valid bytes, so it fits beside the tail in one line.
  assign w_short_end = src_eth_strip_padbytes >= PADBYTES_W'(B - 14);

  always_comb begin
    w_src_rdy = 1'b0;
    case (r_state)
      FIRST:   w_src_rdy = w_hdr_free;
      BODY:    w_src_rdy = w_pay_free;
      DRAIN:   w_src_rdy = 1'b0;
      DROP:    w_src_rdy = 1'b1;
      default: w_src_rdy = 1'b0;
    endcase
  end

  assign w_acc = src_eth_strip_val && w_src_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FIRST;
      r_tail      <= '0;
      r_drain_pad <= '0;
      r_hdr_val   <= 1'b0;
      r_hdr_dst   <= '0;
      r_hdr_src   <= '0;
      r_hdr_type  <= '0;
      r_hdr_size  <= '0;
      r_pay_val   <= 1'b0;
      r_pay_data  <= '0;
      r_pay_last  <= 1'b0;
      r_pay_pad   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (r_hdr_val && hdr_eth_strip_rdy) r_hdr_val <= 1'b0;
      if (r_pay_val && pay_eth_strip_rdy) r_pay_val <= 1'b0;
      case (r_state)
        FIRST: if (w_acc) begin
          if (!src_eth_strip_startframe) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
          end else if (w_runt) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
            if (!src_eth_strip_endframe) r_state <= DROP;
          end else begin
            r_hdr_val  <= 1'b1;
            r_hdr_dst  <= src_eth_strip_data[DATA_W-1 -: 48];
            r_hdr_src  <= src_eth_strip_data[DATA_W-49 -: 48];
            r_hdr_type <= src_eth_strip_data[DATA_W-97 -: 16];
            r_hdr_size <= src_eth_strip_frame_size - SIZE_W'(14);
            r_tail     <= src_eth_strip_data[TAIL_W-1:0];
            if (src_eth_strip_endframe) begin
              r_drain_pad <= src_eth_strip_padbytes + PADBYTES_W'(14);
              r_state     <= DRAIN;
            end else begin
              r_state <= BODY;
            end
          end
        end
        // Each body line pairs the previous tail with the head of the current line.
        BODY: if (w_acc) begin
          r_pay_val <= 1'b1;
          r_tail    <= src_eth_strip_data[TAIL_W-1:0];
          if (src_eth_strip_endframe && w_short_end) begin
            r_pay_pad  <= src_eth_strip_padbytes - PADBYTES_W'(B - 14);
            r_pay_data <= f_zero_pad({r_tail, src_eth_strip_data[DATA_W-1 -: HDR_W]},
                                     src_eth_strip_padbytes - PADBYTES_W'(B - 14));
            r_pay_last <= 1'b1;
            r_state    <= FIRST;
          end else begin
            r_pay_data <= {r_tail, src_eth_strip_data[DATA_W-1 -: HDR_W]};
            r_pay_last <= 1'b0;
            r_pay_pad  <= '0;
            if (src_eth_strip_endframe) begin
              r_drain_pad <= src_eth_strip_padbytes + PADBYTES_W'(14);
              r_state     <= DRAIN;
            end
          end
        end
        DRAIN: if (w_pay_free) begin
          r_pay_val  <= 1'b1;
          r_pay_data <= f_zero_pad({r_tail, {HDR_W{1'b0}}}, r_drain_pad);
          r_pay_last <= 1'b1;
          r_pay_pad  <= r_drain_pad;
          r_state    <= FIRST;
        end
        DROP: if (w_acc && src_eth_strip_endframe) r_state <= FIRST;
        default: r_state <= FIRST;
      endcase
    end
  end

  assign eth_strip_src_rdy          = w_src_rdy;
  assign eth_strip_hdr_val          = r_hdr_val;
  assign eth_strip_hdr_dst_mac      = r_hdr_dst;
  assign eth_strip_hdr_src_mac      = r_hdr_src;
  assign eth_strip_hdr_ethertype    = r_hdr_type;
  assign eth_strip_hdr_payload_size = r_hdr_size;
  assign eth_strip_pay_val          = r_pay_val;
  assign eth_strip_pay_data         = r_pay_data;
  assign eth_strip_pay_last         = r_pay_last;
  assign eth_strip_pay_padbytes     = r_pay_pad;
  assign eth_strip_drop_cnt         = r_drop_cnt;

endmodule

// File: tb/tb_eth_hdr_strip.sv
// Bench for eth_hdr_strip at DATA_W=256: table of frames checked against a byte-level
// reference model, plus hand sequences for stray lines, DROP, back-pressure and reset.
module tb_eth_hdr_strip;

  localparam int DATA_W = 256;
  localparam int PW     = 5;
  localparam int SW     = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              src_val = 1'b0;
  logic [DATA_W-1:0] src_data = '0;
  logic              src_sf = 1'b0;
  logic [SW-1:0]     src_fs = '0;
  logic              src_ef = 1'b0;
  logic [PW-1:0]     src_pad = '0;
  logic              src_rdy;
  logic              hdr_val;
  logic [47:0]       hdr_dst;
  logic [47:0]       hdr_src;
  logic [15:0]       hdr_type;
  logic [SW-1:0]     hdr_size;
  logic              hdr_rdy = 1'b1;
  logic              pay_val;
  logic [DATA_W-1:0] pay_data;
  logic              pay_last;
  logic [PW-1:0]     pay_pad;
  logic              pay_rdy = 1'b1;
  logic [15:0]       drop_cnt;

  always #5 clk = ~clk;

  eth_hdr_strip #(.DATA_W(DATA_W), .PADBYTES_W(PW), .SIZE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_eth_strip_val(src_val), .src_eth_strip_data(src_data),
    .src_eth_strip_startframe(src_sf), .src_eth_strip_frame_size(src_fs),
    .src_eth_strip_endframe(src_ef), .src_eth_strip_padbytes(src_pad),
    .eth_strip_src_rdy(src_rdy),
    .eth_strip_hdr_val(hdr_val), .eth_strip_hdr_dst_mac(hdr_dst),
    .eth_strip_hdr_src_mac(hdr_src), .eth_strip_hdr_ethertype(hdr_type),
    .eth_strip_hdr_payload_size(hdr_size), .hdr_eth_strip_rdy(hdr_rdy),
    .eth_strip_pay_val(pay_val), .eth_strip_pay_data(pay_data),
    .eth_strip_pay_last(pay_last), .eth_strip_pay_padbytes(pay_pad),
    .pay_eth_strip_rdy(pay_rdy), .eth_strip_drop_cnt(drop_cnt)
  );

  typedef struct { logic [47:0] dst; logic [47:0] src; logic [15:0] et; logic [15:0] sz; } hdr_t;
  typedef struct { logic [DATA_W-1:0] d; logic last; logic [PW-1:0] pad; } pay_t;
  typedef struct { int len; int seed; int exp_lines; int exp_last_pad; int exp_drops; } vec_t;

  hdr_t exp_hdr[$];
  pay_t exp_pay[$];
  int   checks = 0;
  int   errors = 0;
  int   rx_hdr = 0;
  int   rx_lines = 0;
  int   last_pad_seen = 0;
  logic rnd_en = 1'b0;
  logic [7:0] fb [0:255];

  hdr_t eh;
  pay_t ep;
  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] data_prev = '0;

  always @(posedge clk) begin
    #1;
    pay_rdy = rnd_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Output monitors: a beat transfers on the next posedge when val and rdy are high here.
  always @(negedge clk) begin
    if (rst_n && hdr_val && hdr_rdy) begin
      rx_hdr++;
      checks++;
      if (exp_hdr.size() == 0) begin
        errors++;
        $display("FAIL hdr_unexpected got dst=%h size=%0d want none", hdr_dst, hdr_size);
      end else begin
        eh = exp_hdr.pop_front();
        if (hdr_dst != eh.dst || hdr_src != eh.src || hdr_type != eh.et || hdr_size != eh.sz) begin
          errors++;
          $display("FAIL hdr_fields got %h/%h/%h/%0d want %h/%h/%h/%0d",
                   hdr_dst, hdr_src, hdr_type, hdr_size, eh.dst, eh.src, eh.et, eh.sz);
        end
      end
    end
    if (rst_n && pay_val && pay_rdy) begin
      rx_lines++;
      last_pad_seen = int'(pay_pad);
      checks++;
      if (exp_pay.size() == 0) begin
        errors++;
        $display("FAIL pay_unexpected got %h want none", pay_data);
      end else begin
        ep = exp_pay.pop_front();
        if (pay_data != ep.d || pay_last != ep.last || pay_pad != ep.pad) begin
          errors++;
          $display("FAIL pay_line got %h last=%0b pad=%0d want %h last=%0b pad=%0d",
                   pay_data, pay_last, pay_pad, ep.d, ep.last, ep.pad);
        end
      end
    end
    if (rst_n && stall_prev) begin
      checks++;
      if (!pay_val || pay_data != data_prev) begin
        errors++;
        $display("FAIL pay_stall_stable got val=%0b %h want val=1 %h", pay_val, pay_data, data_prev);
      end
    end
    stall_prev = rst_n && pay_val && !pay_rdy;
    data_prev  = pay_data;
    if (rst_n && src_val && src_sf && hdr_val && !hdr_rdy) begin
      checks++;
      if (src_rdy) begin
        errors++;
        $display("FAIL src_rdy_hdr_full got 1 want 0");
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic make_frame(input int len, input int seed);
    for (int i = 0; i < 256; i++) fb[i] = (i < len) ? 8'((seed * 13 + i * 7 + 1) & 255) : 8'hA5;
  endtask

  function automatic logic [DATA_W-1:0] line_of(input int base, input int limit);
    logic [DATA_W-1:0] l;
    l = '0;
    for (int j = 0; j < 32; j++) begin
      if (base + j < limit) l[DATA_W-1-8*j -: 8] = fb[base + j];
    end
    return l;
  endfunction

  task automatic push_expect(input int len);
    hdr_t h;
    pay_t p;
    int   plen;
    int   n;
    if (len >= 15) begin
      h.dst = '0; h.src = '0;
      for (int j = 0; j < 6; j++) h.dst = {h.dst[39:0], fb[j]};
      for (int j = 6; j < 12; j++) h.src = {h.src[39:0], fb[j]};
      h.et = {fb[12], fb[13]};
      h.sz = 16'(len - 14);
      exp_hdr.push_back(h);
      plen = len - 14;
      n = (plen + 31) / 32;
      for (int k = 0; k < n; k++) begin
        p.d    = line_of(14 + 32 * k, len);
        p.last = (k == n - 1);
        p.pad  = (k == n - 1) ? PW'(32 * n - plen) : '0;
        exp_pay.push_back(p);
      end
    end
  endtask

  task automatic send_line(input logic [DATA_W-1:0] d, input logic sf, input logic [SW-1:0] fs,
                           input logic ef, input logic [PW-1:0] pad);
    int   n;
    logic a;
    bit   done;
    src_val = 1'b1; src_data = d; src_sf = sf; src_fs = fs; src_ef = ef; src_pad = pad;
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      a = src_rdy;
      @(posedge clk);
      #1;
      if (a) begin
        done = 1;
      end else begin
        n++;
        if (n > 1000) begin
          checks++;
          errors++;
          $display("FAIL src_accept_timeout got no rdy want accept");
          done = 1;
        end
      end
    end
  endtask

  task automatic idle();
    src_val = 1'b0; src_sf = 1'b0; src_ef = 1'b0;
  endtask

  task automatic send_frame(input int len, input int seed);
    int nl;
    make_frame(len, seed);
    push_expect(len);
    nl = (len + 31) / 32;
    for (int j = 0; j < nl; j++)
      send_line(line_of(32 * j, 256), j == 0, SW'(len), j == nl - 1,
                (j == nl - 1) ? PW'(32 * nl - len) : PW'(0));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_hdr.size() != 0 || exp_pay.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", exp_hdr.size() + exp_pay.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[10];
    int   l0;
    vecs[0] = '{64, 1, 2, 14, 0};
    vecs[1] = '{20, 2, 1, 26, 0};
    vecs[2] = '{46, 3, 1, 0, 0};
    vecs[3] = '{10, 4, 0, 0, 1};
    vecs[4] = '{64, 1, 2, 14, 1};
    vecs[5] = '{15, 5, 1, 31, 1};
    vecs[6] = '{47, 6, 2, 31, 1};
    vecs[7] = '{78, 7, 2, 0, 1};
    vecs[8] = '{14, 8, 0, 0, 2};
    vecs[9] = '{40, 9, 1, 6, 2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hdr_val", int'(hdr_val), 0);
    check("rst_pay_val", int'(pay_val), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    check("rst_pay_data_zero", int'(pay_data == '0), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      l0 = rx_lines;
      send_frame(vecs[v].len, vecs[v].seed);
      idle();
      wait_idle();
      check($sformatf("vec%0d_lines", v), rx_lines - l0, vecs[v].exp_lines);
      if (vecs[v].exp_lines > 0) check($sformatf("vec%0d_last_pad", v), last_pad_seen, vecs[v].exp_last_pad);
      check($sformatf("vec%0d_drop_cnt", v), int'(drop_cnt), vecs[v].exp_drops);
    end

    // Stray line outside any frame.
    send_line({8{32'hDEADBEEF}}, 1'b0, 16'd0, 1'b1, 5'd0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("stray_drop_cnt", int'(drop_cnt), 3);

    // Multi-line runt: remainder is swallowed in DROP without further counting.
    send_line({8{32'h01020304}}, 1'b1, 16'd8, 1'b0, 5'd0);
    send_line({8{32'h05060708}}, 1'b0, 16'd0, 1'b1, 5'd0);
    idle();
    l0 = rx_lines;
    send_frame(64, 11);
    idle();
    wait_idle();
    check("drop_state_cnt", int'(drop_cnt), 4);
    check("after_drop_lines", rx_lines - l0, 2);

    // Header back-pressure for 20 cycles with random payload back-pressure.
    l0 = rx_lines;
    rx_hdr = 0;
    hdr_rdy = 1'b0;
    rnd_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 100; i++) send_frame(64, 100 + i);
        idle();
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        hdr_rdy = 1'b1;
      end
    join
    wait_idle();
    rnd_en = 1'b0;
    check("stress_hdrs", rx_hdr, 100);
    check("stress_lines", rx_lines - l0, 200);
    check("stress_drop_cnt", int'(drop_cnt), 4);

    // Reset in the middle of BODY.
    make_frame(64, 77);
    push_expect(64);
    send_line(line_of(0, 256), 1'b1, 16'd64, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    check("midrst_hdr_val", int'(hdr_val), 0);
    check("midrst_pay_val", int'(pay_val), 0);
    check("midrst_src_rdy_hdr_pending", int'(exp_hdr.size()), 0);
    exp_hdr.delete();
    exp_pay.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    l0 = rx_lines;
    send_frame(64, 78);
    idle();
    wait_idle();
    check("postrst_lines", rx_lines - l0, 2);
    check("postrst_drop_cnt", int'(drop_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
